// File: rtl/fifo_rd_stream.sv
// FIFO read-side consumer: pops words into a 2-entry skid buffer and frames them into bursts.
// Optional beat/burst statistics counters are enabled with FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
    parameter int B  = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          flush,
    input  logic [LW-1:0] burst_len,
    input  logic          fifo_empty,
    input  logic [B-1:0]  fifo_r_data,
    output logic          fifo_rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [B-1:0]  m_data,
    output logic          m_last,
`ifdef FIFO_RD_STREAM_STATS_EN
    output logic [31:0]   beat_cnt,
    output logic [15:0]   burst_cnt,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {S0, S1, S2} state_t;

    state_t        state, state_nxt;
    logic [B-1:0]  head_data, skid_data;
    logic          head_last, skid_last;
    logic [LW-1:0] pop_cnt, len_reg, len_eff;
    logic          pop, acc, pop_last, head_load;

    // Gated by reset_n so the pop request drops as soon as reset asserts.
    assign pop = reset_n & en & ~fifo_empty & ~flush & (state != S2);
    assign acc = m_valid & m_ready;

    // The first pop of a burst frames itself with the length being latched.
    assign len_eff  = (pop_cnt == '0) ? burst_len : len_reg;
    assign pop_last = (len_eff != '0) && (pop_cnt == len_eff - LW'(1));

    assign head_load = pop & ((state == S0) | acc);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S0: if (pop) state_nxt = S1;
            S1: begin
                if (pop & ~acc)
                    state_nxt = S2;
                else if (~pop & acc)
                    state_nxt = S0;
            end
            S2: if (acc) state_nxt = S1;
            default: state_nxt = S0;
        endcase
        if (flush)
            state_nxt = S0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S0;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pop_cnt   <= '0;
            len_reg   <= '0;
            head_data <= '0;
            head_last <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else if (flush) begin
            pop_cnt   <= '0;
            head_data <= '0;
            head_last <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else begin
            if (pop) begin
                pop_cnt <= pop_last ? '0 : pop_cnt + LW'(1);
                if (pop_cnt == '0)
                    len_reg <= burst_len;
            end
            if (head_load) begin
                head_data <= fifo_r_data;
                head_last <= pop_last;
            end else if (pop) begin
                skid_data <= fifo_r_data;
                skid_last <= pop_last;
            end else if (acc && state == S2) begin
                head_data <= skid_data;
                head_last <= skid_last;
            end
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt  <= '0;
            burst_cnt <= '0;
        end else if (flush) begin
            beat_cnt  <= '0;
            burst_cnt <= '0;
        end else if (acc) begin
            if (beat_cnt != 32'hFFFF_FFFF)
                beat_cnt <= beat_cnt + 32'd1;
            if (m_last && burst_cnt != 16'hFFFF)
                burst_cnt <= burst_cnt + 16'd1;
        end
    end
`endif

    assign fifo_rd = pop;
    assign m_valid = (state != S0);
    assign m_data  = head_data;
    assign m_last  = head_last;
    assign busy    = m_valid;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a queue-based FIFO model.
// Stats checks are compiled in when FIFO_RD_STREAM_STATS_EN is defined.
module tb_fifo_rd_stream;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       flush;
    logic [7:0] burst_len;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_rd;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] beat_cnt;
    logic [15:0] burst_cnt;
`endif

    int vecs = 0;
    int errs = 0;
    int beats;
    logic [7:0] q[$];
    logic [7:0] dq;

    fifo_rd_stream #(.B(8), .LW(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .flush       (flush),
        .burst_len   (burst_len),
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_rd     (fifo_rd),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
`ifdef FIFO_RD_STREAM_STATS_EN
        .beat_cnt    (beat_cnt),
        .burst_cnt   (burst_cnt),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        fifo_empty  = (q.size() == 0);
        fifo_r_data = fifo_empty ? 8'h00 : q[0];
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        refresh();
    endtask

    // FIFO model: rd sampled at the edge, r_data updated just after it.
    always @(posedge clk) begin
        if (fifo_rd) begin
            #1;
            dq = q.pop_front();
            refresh();
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        burst_len = 8'd0;
        m_ready   = 1'b0;
        q.delete();
        refresh();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd", fifo_rd, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // three words, unframed, full throughput
        push(8'h11); push(8'h22); push(8'h33);
        en = 1'b1; m_ready = 1'b1;
        #1;
        chk("s1_rd0", fifo_rd, 1);
        chk("s1_v0", m_valid, 0);
        @(negedge clk); #1;
        chk("s1_v1", m_valid, 1);
        chk("s1_d1", m_data, 8'h11);
        chk("s1_l1", m_last, 0);
        @(negedge clk); #1;
        chk("s1_d2", m_data, 8'h22);
        chk("s1_l2", m_last, 0);
        @(negedge clk); #1;
        chk("s1_d3", m_data, 8'h33);
        chk("s1_l3", m_last, 0);
        chk("s1_rd_empty", fifo_rd, 0);
        @(negedge clk); #1;
        chk("s1_v_end", m_valid, 0);
        chk("s1_busy_end", busy, 0);

        // backpressure: two pops fill the buffer, then drain
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hA1 + 8'(i));
        #1;
        chk("s2_rd0", fifo_rd, 1);
        @(negedge clk); #1;
        chk("s2_d_a1", m_data, 8'hA1);
        chk("s2_rd1", fifo_rd, 1);
        @(negedge clk); #1;
        chk("s2_full_rd", fifo_rd, 0);
        chk("s2_hold1", m_data, 8'hA1);
        @(negedge clk); #1;
        chk("s2_hold2", m_data, 8'hA1);
        chk("s2_qsize", q.size(), 3);
        chk("s2_full_rd2", fifo_rd, 0);
        m_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk); #1;
            chk("s2_drain_v", m_valid, 1);
            chk("s2_drain_d", m_data, 8'hA1 + 8'(i));
        end
        @(negedge clk); #1;
        chk("s2_v_end", m_valid, 0);
        chk("s2_q_end", q.size(), 0);

        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;

        // burst_len = 3 over 7 words
        burst_len = 8'd3;
        for (int i = 0; i < 7; i++) push(8'hB1 + 8'(i));
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            chk("b3_d", m_data, 8'hB1 + 8'(i));
            chk("b3_last", m_last, (i == 2 || i == 5) ? 1 : 0);
        end
        @(negedge clk); #1;
        chk("b3_v_end", m_valid, 0);

        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;

        // burst_len = 1: every beat is last
        burst_len = 8'd1;
        for (int i = 0; i < 3; i++) push(8'hE1 + 8'(i));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("b1_d", m_data, 8'hE1 + 8'(i));
            chk("b1_last", m_last, 1);
        end
        @(negedge clk); #1;
        chk("b1_v_end", m_valid, 0);

        // burst_len 4 -> 2 changed after beat 2
        burst_len = 8'd4;
        for (int i = 0; i < 6; i++) push(8'hF1 + 8'(i));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("b42_d", m_data, 8'hF1 + 8'(i));
            chk("b42_last", m_last, (i == 3 || i == 5) ? 1 : 0);
            if (i == 1) burst_len = 8'd2;
        end
        @(negedge clk); #1;
        chk("b42_v_end", m_valid, 0);

        // flush while full with m_ready high
        burst_len = 8'd3;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hC1 + 8'(i));
        @(negedge clk); #1;
        chk("fl_d_c1", m_data, 8'hC1);
        @(negedge clk); #1;
        chk("fl_full_rd", fifo_rd, 0);
        flush = 1'b1; m_ready = 1'b1;
        #1;
        chk("fl_rd_flush", fifo_rd, 0);
        @(negedge clk); #1;
        chk("fl_v", m_valid, 0);
        chk("fl_busy", busy, 0);
        chk("fl_qsize", q.size(), 3);
        chk("fl_rd_hold", fifo_rd, 0);
        flush = 1'b0;
        #1;
        chk("fl_rd_resume", fifo_rd, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("fl_d", m_data, 8'hC3 + 8'(i));
            chk("fl_last", m_last, (i == 2) ? 1 : 0);
        end
        @(negedge clk); #1;
        chk("fl_v_end", m_valid, 0);

        // asynchronous reset between edges
        burst_len = 8'd0;
        for (int i = 0; i < 4; i++) push(8'hD1 + 8'(i));
        @(negedge clk); #1;
        chk("ar_v", m_valid, 1);
        chk("ar_d", m_data, 8'hD1);
        chk("ar_rd", fifo_rd, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_v0", m_valid, 0);
        chk("ar_rd0", fifo_rd, 0);
        chk("ar_busy0", busy, 0);
        chk("ar_d0", m_data, 0);
        q.delete();
        refresh();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
`ifdef FIFO_RD_STREAM_STATS_EN
        chk("st_beat0", beat_cnt, 0);
        chk("st_burst0", burst_cnt, 0);
`endif

        // ten accepts after reset
        burst_len = 8'd5;
        for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
        beats = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (m_valid && m_ready) beats++;
        end
        chk("ten_beats", beats, 10);
        chk("ten_v_end", m_valid, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
        chk("st_beat10", beat_cnt, 10);
        chk("st_burst2", burst_cnt, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
